// File: rtl/ps2_key_decoder_if.sv
// Byte stream from the PS/2 receiver into the key decoder, and the decoded
// command strobes plus debug state coming back out.
interface ps2_key_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       hit_pressed;
  logic       stand_pressed;
  logic       deal_pressed;
  logic [2:0] keys_held;
  logic [7:0] last_code;
  logic       seq_error;

  modport master (
    output ps2_byte, ps2_byte_valid,
    input  hit_pressed, stand_pressed, deal_pressed, keys_held, last_code, seq_error
  );

  modport slave (
    input  ps2_byte, ps2_byte_valid,
    output hit_pressed, stand_pressed, deal_pressed, keys_held, last_code, seq_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 scan codes into one-shot blackjack command strobes,
// tracking make/break/extended prefixes and per-key held state.
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | no prefix pending; make codes are decoded
// BRK     | F0 seen; next key code is a release
// EXT     | E0 seen; next byte belongs to an extended key
// EXT_BRK | E0 F0 seen; next byte releases an extended key
module ps2_key_decoder #(
  parameter logic [7:0]  HIT_CODE       = 8'h33,
  parameter logic [7:0]  STAND_CODE     = 8'h1B,
  parameter logic [7:0]  DEAL_CODE      = 8'h23,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic             CLOCK_50,
  input logic             reset,
  ps2_key_decoder_if.slave bus
);

  localparam logic [7:0] CODE_BRK      = 8'hF0;
  localparam logic [7:0] CODE_EXT      = 8'hE0;
  localparam logic [7:0] CODE_BAT_PASS = 8'hAA;
  localparam logic [7:0] CODE_BAT_FAIL = 8'hFC;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against the pre-increment value so the timeout fires on the
  // edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;

  logic is_brk, is_ext, is_hit, is_stand, is_deal, is_bat;

  always_comb begin
    is_brk   = (bus.ps2_byte == CODE_BRK);
    is_ext   = (bus.ps2_byte == CODE_EXT);
    is_hit   = (bus.ps2_byte == HIT_CODE);
    is_stand = (bus.ps2_byte == STAND_CODE);
    is_deal  = (bus.ps2_byte == DEAL_CODE);
    is_bat   = (bus.ps2_byte == CODE_BAT_PASS) || (bus.ps2_byte == CODE_BAT_FAIL);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      tmo_cnt           <= '0;
      bus.hit_pressed   <= 1'b0;
      bus.stand_pressed <= 1'b0;
      bus.deal_pressed  <= 1'b0;
      bus.keys_held     <= 3'b000;
      bus.last_code     <= 8'h00;
      bus.seq_error     <= 1'b0;
    end else begin
      bus.hit_pressed   <= 1'b0;
      bus.stand_pressed <= 1'b0;
      bus.deal_pressed  <= 1'b0;
      bus.seq_error     <= 1'b0;

      if (bus.ps2_byte_valid) begin
        bus.last_code <= bus.ps2_byte;
        tmo_cnt       <= '0;
        unique case (state)
          IDLE: begin
            if (is_brk) begin
              state <= BRK;
            end else if (is_ext) begin
              state <= EXT;
            end else if (is_hit) begin
              if (!bus.keys_held[0]) begin
                bus.keys_held[0] <= 1'b1;
                bus.hit_pressed  <= 1'b1;
              end
            end else if (is_stand) begin
              if (!bus.keys_held[1]) begin
                bus.keys_held[1]  <= 1'b1;
                bus.stand_pressed <= 1'b1;
              end
            end else if (is_deal) begin
              if (!bus.keys_held[2]) begin
                bus.keys_held[2] <= 1'b1;
                bus.deal_pressed <= 1'b1;
              end
            end else if (is_bat) begin
              bus.keys_held <= 3'b000;
            end
          end
          BRK: begin
            if (is_brk) begin
              bus.seq_error <= 1'b1;
            end else if (is_ext) begin
              bus.seq_error <= 1'b1;
              state         <= EXT;
            end else begin
              if (is_hit)   bus.keys_held[0] <= 1'b0;
              if (is_stand) bus.keys_held[1] <= 1'b0;
              if (is_deal)  bus.keys_held[2] <= 1'b0;
              state <= IDLE;
            end
          end
          EXT: begin
            if (is_brk) begin
              state <= EXT_BRK;
            end else if (is_ext) begin
              bus.seq_error <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          EXT_BRK: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == CNT_FIRE) begin
          state         <= IDLE;
          tmo_cnt       <= '0;
          bus.seq_error <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + CW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule
